// File: rtl/axi_weight_bias_loader_pkg.sv
// Shared constants for the weight/bias loader and its companion memory slave:
// AXI response codes, loader FSM encoding and the memory word size.
package axi_weight_bias_loader_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_ADDR = 2'd1;
   localparam logic [1:0] ST_DATA = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   localparam int WORD_BYTES = 4;

endpackage

// File: rtl/axi_simple_mem.sv
// Single-outstanding AXI4-Lite-style read slave over a word array, with a
// write port used to preload contents before a load.
module axi_simple_mem
   import axi_weight_bias_loader_pkg::*;
#(
   parameter int DEPTH = 1024
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     S_AXI_ARVALID,
   output logic                     S_AXI_ARREADY,
   input  logic [31:0]              S_AXI_ARADDR,
   output logic                     S_AXI_RVALID,
   input  logic                     S_AXI_RREADY,
   output logic [31:0]              S_AXI_RDATA,
   output logic [1:0]               S_AXI_RRESP,
   input  logic                     wr_en,
   input  logic [$clog2(DEPTH)-1:0] wr_addr,
   input  logic [31:0]              wr_data
);

   localparam int AW = $clog2(DEPTH);

   logic [31:0] mem [0:DEPTH-1];
   logic        rvalid;
   logic [29:0] word_idx;
   logic        in_range;
   logic        unused_addr;

   assign word_idx      = S_AXI_ARADDR[31:2];
   assign in_range      = (word_idx < 30'(DEPTH));
   assign unused_addr   = ^S_AXI_ARADDR[1:0];
   assign S_AXI_ARREADY = ~rvalid;
   assign S_AXI_RVALID  = rvalid;

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rvalid <= 1'b0;
      end else if (S_AXI_ARVALID && !rvalid) begin
         rvalid <= 1'b1;
      end else if (rvalid && S_AXI_RREADY) begin
         rvalid <= 1'b0;
      end
   end

   // Response payload is data: it is only meaningful while rvalid is high.
   always_ff @(posedge clk) begin
      if (S_AXI_ARVALID && !rvalid) begin
         if (in_range) begin
            S_AXI_RDATA <= mem[word_idx[AW-1:0]];
            S_AXI_RRESP <= RESP_OKAY;
         end else begin
            S_AXI_RDATA <= 32'h0;
            S_AXI_RRESP <= RESP_SLVERR;
         end
      end
   end

endmodule

// File: rtl/axi_weight_bias_loader.sv
// Read master that copies W_COUNT signed weight bytes, then B_COUNT signed
// bias bytes, from word-addressed memory into local register arrays.
module axi_weight_bias_loader
   import axi_weight_bias_loader_pkg::*;
#(
   parameter int          W_COUNT   = 756,
   parameter int          B_COUNT   = 28,
   parameter logic [31:0] BASE_ADDR = 32'h0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic        done,
   output logic        M_AXI_ARVALID,
   input  logic        M_AXI_ARREADY,
   output logic [31:0] M_AXI_ARADDR,
   input  logic        M_AXI_RVALID,
   output logic        M_AXI_RREADY,
   input  logic [31:0] M_AXI_RDATA,
   input  logic [1:0]  M_AXI_RRESP
);

   localparam int TOTAL = W_COUNT + B_COUNT;
   localparam int KW    = (TOTAL > 1)   ? $clog2(TOTAL)   : 1;
   localparam int WW    = (W_COUNT > 1) ? $clog2(W_COUNT) : 1;
   localparam int BW    = (B_COUNT > 1) ? $clog2(B_COUNT) : 1;

   localparam logic [KW-1:0] K_LAST   = KW'(TOTAL - 1);
   localparam logic [KW-1:0] K_WCOUNT = KW'(W_COUNT);
   localparam logic [31:0]   STRIDE   = 32'(WORD_BYTES);

   logic signed [7:0] weight_mem [0:W_COUNT-1];
   logic signed [7:0] bias_mem   [0:B_COUNT-1];

   logic [1:0]    state;
   logic [KW-1:0] k;
   logic [31:0]   araddr;
   logic          ar_hs;
   logic          r_hs;
   logic [WW-1:0] w_idx;
   logic [BW-1:0] b_idx;
   logic          unused_bits;

   assign ar_hs         = M_AXI_ARVALID & M_AXI_ARREADY;
   assign r_hs          = M_AXI_RVALID & M_AXI_RREADY;
   assign w_idx         = WW'(k);
   assign b_idx         = BW'(k - K_WCOUNT);
   assign unused_bits   = ^{M_AXI_RDATA[31:8], M_AXI_RRESP};

   assign M_AXI_ARVALID = (state == ST_ADDR);
   assign M_AXI_RREADY  = (state == ST_DATA);
   assign M_AXI_ARADDR  = araddr;
   assign done          = (state == ST_DONE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= ST_IDLE;
         k      <= '0;
         araddr <= 32'h0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  state  <= ST_ADDR;
                  k      <= '0;
                  araddr <= BASE_ADDR;
               end
            end
            ST_ADDR: begin
               if (ar_hs) state <= ST_DATA;
            end
            ST_DATA: begin
               if (r_hs) begin
                  if (k == K_LAST) begin
                     state <= ST_DONE;
                  end else begin
                     k      <= k + 1'b1;
                     araddr <= araddr + STRIDE;
                     state  <= ST_ADDR;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Array capture: no reset, but an abort in the same cycle suppresses the write.
   always_ff @(posedge clk) begin
      if (!rst && state == ST_DATA && r_hs) begin
         if (k < K_WCOUNT) weight_mem[w_idx] <= signed'(M_AXI_RDATA[7:0]);
         else              bias_mem[b_idx]   <= signed'(M_AXI_RDATA[7:0]);
      end
   end

endmodule

// File: tb/tb_axi_weight_bias_loader.sv
// Bench for axi_weight_bias_loader against axi_simple_mem, with optional
// random ARREADY/RVALID gating between master and slave.
module tb_axi_weight_bias_loader;

   localparam int W = 756;
   localparam int B = 28;
   localparam int N = W + B;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        done;
   logic        arvalid, arready, rvalid, rready;
   logic [31:0] araddr, rdata;
   logic [1:0]  rresp;
   logic        s_arvalid, s_arready, s_rvalid, s_rready;
   logic        ar_gate = 1'b1;
   logic        r_gate  = 1'b1;
   bit          stall_en = 1'b0;
   logic        wr_en;
   logic [9:0]  wr_addr;
   logic [31:0] wr_data;

   int vectors = 0;
   int miscompares = 0;

   logic [31:0] img [0:1023];
   logic [31:0] exp_addr = 32'h0;
   bit          pending = 1'b0;
   bit          p_wait = 1'b0;
   logic [31:0] p_addr = 32'h0;

   always #5 clk = ~clk;

   assign arready   = s_arready & ar_gate;
   assign s_arvalid = arvalid & ar_gate;
   assign rvalid    = s_rvalid & r_gate;
   assign s_rready  = rready & r_gate;

   axi_weight_bias_loader #(.W_COUNT(W), .B_COUNT(B), .BASE_ADDR(32'h0)) dut (
      .clk(clk), .rst(rst), .start(start), .done(done),
      .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready), .M_AXI_ARADDR(araddr),
      .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready), .M_AXI_RDATA(rdata),
      .M_AXI_RRESP(rresp)
   );

   axi_simple_mem #(.DEPTH(1024)) u_mem (
      .clk(clk), .rst(rst),
      .S_AXI_ARVALID(s_arvalid), .S_AXI_ARREADY(s_arready), .S_AXI_ARADDR(araddr),
      .S_AXI_RVALID(s_rvalid), .S_AXI_RREADY(s_rready), .S_AXI_RDATA(rdata),
      .S_AXI_RRESP(rresp),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
   );

   // Protocol observer: stable AR while waiting, one outstanding read, sequential addresses.
   always @(negedge clk) begin
      if (stall_en) begin
         ar_gate = ($urandom_range(0, 2) != 0);
         r_gate  = ($urandom_range(0, 2) != 0);
      end else begin
         ar_gate = 1'b1;
         r_gate  = 1'b1;
      end
      #1;
      if (p_wait) begin
         vectors++;
         if (arvalid !== 1'b1 || araddr !== p_addr) begin
            miscompares++;
            $display("FAIL ar_stable: arvalid=%b araddr=%h, required arvalid=1 araddr=%h",
                     arvalid, araddr, p_addr);
         end
      end
      if (rst) begin
         pending = 1'b0;
      end else begin
         if (arvalid && arready) begin
            vectors++;
            if (pending || araddr !== exp_addr) begin
               miscompares++;
               $display("FAIL ar_issue: pending=%b araddr=%h, required pending=0 araddr=%h",
                        pending, araddr, exp_addr);
            end
            exp_addr = exp_addr + 32'd4;
            pending  = 1'b1;
         end
         if (rvalid && rready) pending = 1'b0;
      end
      p_wait = arvalid && !arready && !rst;
      p_addr = araddr;
   end

   task automatic fill_random();
      for (int i = 0; i < 1024; i++) img[i] = $urandom();
   endtask

   task automatic push_mem();
      for (int i = 0; i < N; i++) begin
         @(negedge clk);
         wr_en   = 1'b1;
         wr_addr = 10'(i);
         wr_data = img[i];
      end
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic start_load();
      @(negedge clk);
      exp_addr = 32'h0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input string name, input int budget, inout int cyc);
      while (!done && cyc < budget) begin
         @(negedge clk);
         cyc++;
      end
      if (!done) begin
         vectors++;
         miscompares++;
         $display("FAIL %s_timeout: done=%b after %0d cycles, required done=1", name, done, cyc);
      end
   endtask

   task automatic check_latency(input string name, input int cyc);
      vectors++;
      if (cyc !== 2 * N + 1) begin
         miscompares++;
         $display("FAIL %s_latency: done after %0d cycles, required %0d", name, cyc, 2 * N + 1);
      end
   endtask

   task automatic check_arrays(input string name);
      logic signed [7:0] e;
      for (int i = 0; i < W; i++) begin
         e = img[i][7:0];
         vectors++;
         if (dut.weight_mem[i] !== e) begin
            miscompares++;
            $display("FAIL %s_weight[%0d]: got %0d, required %0d", name, i, dut.weight_mem[i], e);
         end
      end
      for (int i = 0; i < B; i++) begin
         e = img[W + i][7:0];
         vectors++;
         if (dut.bias_mem[i] !== e) begin
            miscompares++;
            $display("FAIL %s_bias[%0d]: got %0d, required %0d", name, i, dut.bias_mem[i], e);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      repeat (3) @(negedge clk);
      #2;
      vectors += 4;
      if (done !== 1'b0)    begin miscompares++; $display("FAIL reset_done: got %b, required 0", done); end
      if (arvalid !== 1'b0) begin miscompares++; $display("FAIL reset_arvalid: got %b, required 0", arvalid); end
      if (rready !== 1'b0)  begin miscompares++; $display("FAIL reset_rready: got %b, required 0", rready); end
      if (araddr !== 32'h0) begin miscompares++; $display("FAIL reset_araddr: got %h, required 0", araddr); end
      rst = 1'b0;
   endtask

   task automatic test_full_load();
      int cyc;
      fill_random();
      img[0] = 32'h0000_00F3;
      img[W] = 32'h0000_0080;
      push_mem();
      start_load();
      cyc = 1;
      wait_done("full", 4 * N, cyc);
      check_latency("full", cyc);
      check_arrays("full");
      vectors += 2;
      if (dut.weight_mem[0] !== -8'sd13) begin
         miscompares++; $display("FAIL sign_weight0: got %0d, required -13", dut.weight_mem[0]);
      end
      if (dut.bias_mem[0] !== -8'sd128) begin
         miscompares++; $display("FAIL sign_bias0: got %0d, required -128", dut.bias_mem[0]);
      end
   endtask

   task automatic test_stalls();
      int cyc;
      fill_random();
      push_mem();
      stall_en = 1'b1;
      start_load();
      cyc = 1;
      wait_done("stall", 30 * N, cyc);
      stall_en = 1'b0;
      check_arrays("stall");
   endtask

   task automatic test_start_ignored();
      int cyc;
      fill_random();
      push_mem();
      start_load();
      repeat (199) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      cyc = 202;
      wait_done("busy", 4 * N, cyc);
      check_latency("busy", cyc);
      check_arrays("busy");
   endtask

   task automatic test_reset_midload();
      int cyc;
      logic signed [7:0] e;
      fill_random();
      push_mem();
      start_load();
      repeat (599) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      #2;
      vectors += 3;
      if (arvalid !== 1'b0) begin miscompares++; $display("FAIL abort_arvalid: got %b, required 0", arvalid); end
      if (rready !== 1'b0)  begin miscompares++; $display("FAIL abort_rready: got %b, required 0", rready); end
      if (done !== 1'b0)    begin miscompares++; $display("FAIL abort_done: got %b, required 0", done); end
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         e = img[i][7:0];
         vectors++;
         if (dut.weight_mem[i] !== e) begin
            miscompares++;
            $display("FAIL abort_kept[%0d]: got %0d, required %0d", i, dut.weight_mem[i], e);
         end
      end
      start_load();
      cyc = 1;
      wait_done("restart", 4 * N, cyc);
      check_latency("restart", cyc);
      check_arrays("restart");
   endtask

   task automatic test_reload();
      int cyc;
      fill_random();
      push_mem();
      vectors++;
      if (done !== 1'b1) begin miscompares++; $display("FAIL reload_pre_done: got %b, required 1", done); end
      start_load();
      vectors++;
      if (done !== 1'b0) begin miscompares++; $display("FAIL reload_drop: got %b, required 0", done); end
      cyc = 1;
      wait_done("reload", 4 * N, cyc);
      check_latency("reload", cyc);
      check_arrays("reload");
   endtask

   initial begin
      test_reset();
      test_full_load();
      test_stalls();
      test_start_ignored();
      test_reset_midload();
      test_reload();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
